// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a carry flop, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic s_bit;
  logic c_bit;
  logic last_bit;

  always_comb begin
    s_bit    = a_q[0] ^ b_q[0] ^ carry_q;
    c_bit    = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        res_d   = {s_bit, res_q[WIDTH-1:1]};
        carry_d = c_bit;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          // the final sum bit is taken straight from the adder, not from res_q
          sum_d   = {s_bit, res_q[WIDTH-1:1]};
          cout_d  = c_bit;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // carry into the MSB is carry_q while the last bit is in the adder
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == RUN && last_bit) ovf_d = carry_q ^ c_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder (WIDTH=8), table-driven plus corner sequences.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

`ifdef SERIAL_ADDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation and wait (bounded) for done; checks latency and busy.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    int unsigned n;
    int unsigned busy_bad;
    a = ia; b = ib; cin = ic; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~ia; b = ~ib; cin = ~ic;
    busy_bad = 0;
    n = 0;
    while (n < 3 * W) begin
      tick();
      n++;
      if (done) break;
      if (busy !== 1'b1) busy_bad++;
    end
    check("latency", n, W);
    check("busy_during_run", busy_bad, 0);
    check("busy_at_done", busy, 0);
    check("sum", sum, es);
    check("cout", cout, ec);
    check("ovf", ovf, eo & OVF_ON);
  endtask

  initial begin
    int unsigned dones;
    int unsigned last_n;
    tbl[0] = '{8'h3C, 8'h15, 1'b0, 8'h51, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
    tbl[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{8'h55, 8'h55, 1'b0, 8'hAA, 1'b0, 1'b1};
    tbl[8] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Back-to-back: each op starts while the previous is in DONE.
    for (int i = 0; i < 9; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, tbl[i].ovf);
    tick();
    check("idle_after_done", {30'd0, busy, done}, 0);

    // Start ignored while busy.
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        dones++;
        check("ign_sum", sum, 8'h30);
        check("ign_cout", cout, 0);
      end
      tick();
    end
    check("ign_done_count", dones, 1);
    check("ign_idle", busy, 0);

    // Asynchronous reset mid-operation.
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) dones++;
      tick();
    end
    check("mid_rst_no_done", dones, 0);
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    tick();

    // Start held high: one result every W+1 cycles.
    a = 8'h05; b = 8'h03; cin = 1'b0; start = 1'b1;
    dones = 0;
    last_n = 0;
    for (int unsigned n = 1; n <= 30; n++) begin
      tick();
      if (done) begin
        dones++;
        check("hold_sum", sum, 8'h08);
        check("hold_spacing", n - last_n, W + 1);
        last_n = n;
        tick();
        n++;
        check("hold_busy_after_done", busy, 1);
      end
    end
    start = 1'b0;
    check("hold_done_count", dones, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
